// File: rtl/alu_pipe.sv
// Single-stage ALU with a valid/ready handshake on both sides and an optional
// accumulator that can stand in for operand A.
module alu_pipe #(
  parameter int WIDTH  = 8,
  parameter int ACC_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  input  logic             acc_sel,
  input  logic             acc_wr,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH+1:0] y,
  output logic [3:0]       flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] acc_q
);

  localparam int W2 = WIDTH + 2;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] lg;
  logic [W2-1:0]    ax;
  logic [W2-1:0]    bx;
  logic [W2-1:0]    res;
  logic             cout;
  logic             ovf;
  logic             xfer;

  assign in_ready = !out_valid || out_ready;
  assign xfer     = in_valid && in_ready;

  assign op_a = ((ACC_EN != 0) && acc_sel) ? acc_q : a;
  assign ax   = {{2{op_a[WIDTH-1]}}, op_a};
  assign bx   = {{2{b[WIDTH-1]}}, b};

  // The extended add carries into bit WIDTH exactly what the WIDTH-bit unsigned
  // add carries out, so cout = sum[WIDTH] ^ opA[WIDTH] ^ opB[WIDTH].
  // Decrement adds all-ones, whose bit WIDTH is 1.
  always_comb begin
    res  = '0;
    lg   = '0;
    cout = 1'b0;
    case (sel)
      4'h0: begin res = ax + W2'(1); cout = res[WIDTH] ^ ax[WIDTH];          end
      4'h1: begin res = ax - W2'(1); cout = ~(res[WIDTH] ^ ax[WIDTH]);       end
      4'h2: begin res = ax << 1;     cout = op_a[WIDTH-1];                   end
      4'h3: begin res = bx + W2'(1); cout = res[WIDTH] ^ bx[WIDTH];          end
      4'h4: begin res = bx - W2'(1); cout = ~(res[WIDTH] ^ bx[WIDTH]);       end
      4'h5: begin res = bx << 1;     cout = b[WIDTH-1];                      end
      4'h6: begin res = ax + bx;     cout = res[WIDTH] ^ ax[WIDTH] ^ bx[WIDTH]; end
      4'h7: begin res = ax << 2;     cout = op_a[WIDTH-1] | op_a[WIDTH-2];   end
      4'h8: lg = ~op_a;
      4'h9: lg = ~b;
      4'hA: lg = op_a & b;
      4'hB: lg = op_a | b;
      4'hC: lg = op_a ^ b;
      4'hD: lg = ~(op_a ^ b);
      4'hE: lg = ~(op_a & b);
      4'hF: lg = ~(op_a | b);
      default: res = '0;
    endcase
    if (sel[3]) res = {{2{lg[WIDTH-1]}}, lg};
  end

  assign ovf = !sel[3] && !((&res[W2-1:WIDTH-1]) || !(|res[W2-1:WIDTH-1]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
      flags     <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      y         <= res;
      flags     <= {res[W2-1], (res == '0), ovf, cout};
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  generate
    if (ACC_EN != 0) begin : g_acc
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          acc_q <= '0;
        else if (xfer && acc_wr)
          acc_q <= res[WIDTH-1:0];
      end
    end else begin : g_no_acc
      assign acc_q = '0;
    end
  endgenerate

endmodule

// File: tb/tb_alu_pipe.sv
// Directed vectors plus a randomized run checked through a scoreboard against
// an integer-arithmetic reference model.
module tb_alu_pipe;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [3:0]     sel = '0;
  logic           acc_sel = 1'b0;
  logic           acc_wr = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b1;
  logic           in_ready;
  logic [W+1:0]   y;
  logic [3:0]     flags;
  logic           out_valid;
  logic [W-1:0]   acc_q;

  alu_pipe #(.WIDTH(W), .ACC_EN(1)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .sel(sel), .acc_sel(acc_sel),
    .acc_wr(acc_wr), .in_valid(in_valid), .in_ready(in_ready), .y(y),
    .flags(flags), .out_valid(out_valid), .out_ready(out_ready), .acc_q(acc_q)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W+1:0] y;
    logic [3:0]   f;
    logic [W-1:0] acc;
  } exp_t;

  int   checks = 0;
  int   passes = 0;
  bit   sb_on  = 1'b0;
  int   acc_m  = 0;
  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Works on true signed integers; every op fits in W+2 bits, so the low W+2
  // bits of the integer are the registered result.
  function automatic exp_t model(input int av, input int bv, input logic [3:0] s);
    exp_t        e;
    int          r = 0;
    int          au = av & ((1 << W) - 1);
    int          bu = bv & ((1 << W) - 1);
    logic        c = 1'b0;
    logic [31:0] rv;
    case (s)
      4'h0: begin r = av + 1;  c = (au + 1) >= (1 << W);  end
      4'h1: begin r = av - 1;  c = (au != 0);             end
      4'h2: begin r = av * 2;  c = au >= (1 << (W - 1)); end
      4'h3: begin r = bv + 1;  c = (bu + 1) >= (1 << W);  end
      4'h4: begin r = bv - 1;  c = (bu != 0);             end
      4'h5: begin r = bv * 2;  c = bu >= (1 << (W - 1)); end
      4'h6: begin r = av + bv; c = (au + bu) >= (1 << W); end
      4'h7: begin r = av * 4;  c = au >= (1 << (W - 2)); end
      4'h8: r = ~av;
      4'h9: r = ~bv;
      4'hA: r = av & bv;
      4'hB: r = av | bv;
      4'hC: r = av ^ bv;
      4'hD: r = ~(av ^ bv);
      4'hE: r = ~(av & bv);
      default: r = ~(av | bv);
    endcase
    rv     = r;
    e.y    = rv[W+1:0];
    e.f[3] = (r < 0);
    e.f[2] = (r == 0);
    e.f[1] = !s[3] && ((r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1))));
    e.f[0] = c;
    e.acc  = '0;
    return e;
  endfunction

  task automatic set_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [3:0] ts,
                        input logic tas, input logic taw);
    a = ta; b = tb; sel = ts; acc_sel = tas; acc_wr = taw; in_valid = 1'b1;
  endtask

  task automatic push_if_xfer(inout int n);
    exp_t        e;
    int          av;
    logic [31:0] accv;
    if (in_valid && in_ready) begin
      av = acc_sel ? acc_m : int'($signed(a));
      e  = model(av, int'($signed(b)), sel);
      if (acc_wr) acc_m = int'($signed(e.y[W-1:0]));
      accv  = acc_m;
      e.acc = accv[W-1:0];
      sbq.push_back(e);
      n++;
    end
  endtask

  task automatic do_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic [3:0] ts, input logic [W+1:0] ey, input logic [3:0] ef);
    @(posedge clk); #1 set_op(ta, tb, ts, 1'b0, 1'b0);
    @(posedge clk); #1 in_valid = 1'b0;
    chk({name, "_valid"}, out_valid, 1'b1);
    chk({name, "_y"}, y, ey);
    chk({name, "_flags"}, flags, ef);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_on) begin
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          $display("FAIL unexpected_output: got y=%0h with no outstanding request", y);
        end else begin
          e = sbq.pop_front();
          chk("sb_y", y, e.y);
          chk("sb_flags", flags, e.f);
          chk("sb_acc_q", acc_q, e.acc);
        end
      end
    end
  end

  initial begin
    int n;
    int cyc;
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_y", y, 6'd0);
    chk("rst_flags", flags, 4'd0);
    chk("rst_acc_q", acc_q, 4'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(negedge clk); @(negedge clk); rst = 1'b0;

    out_ready = 1'b1;
    do_op("add_ovf", 4'd7, 4'd1, 4'h6, 6'b001000, 4'b0010);
    do_op("shl2", 4'b1000, 4'd0, 4'h7, 6'b100000, 4'b1011);
    do_op("and", 4'd5, 4'd3, 4'hA, 6'd1, 4'b0000);

    // accumulator written and reused back-to-back
    @(posedge clk); #1 set_op(4'd0, 4'd2, 4'h3, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("acc1_y", y, 6'd3);
    chk("acc1_acc_q", acc_q, 4'd3);
    set_op(4'd0, 4'd0, 4'h0, 1'b1, 1'b1);
    @(posedge clk); #1 in_valid = 1'b0;
    chk("acc2_y", y, 6'd4);
    chk("acc2_acc_q", acc_q, 4'd4);

    // output stall for three cycles with a competing request
    @(posedge clk); #1 out_ready = 1'b0; set_op(4'd2, 4'd0, 4'h0, 1'b0, 1'b0);
    @(posedge clk); #1 set_op(4'd1, 4'd1, 4'h6, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_y", y, 6'd3);
      chk("stall_in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
    end
    chk("stall_hold_y", y, 6'd3);
    chk("stall_acc_q", acc_q, 4'd4);
    out_ready = 1'b1;
    #1 chk("release_in_ready", in_ready, 1'b1);
    @(posedge clk); #1 in_valid = 1'b0;
    chk("resume_valid", out_valid, 1'b1);
    chk("resume_y", y, 6'd2);
    @(posedge clk); #1;
    chk("drain_valid", out_valid, 1'b0);
    chk("drain_hold_y", y, 6'd2);

    // asynchronous reset while stalled
    out_ready = 1'b0;
    set_op(4'd0, 4'd5, 4'h3, 1'b0, 1'b1);
    @(posedge clk); #1 in_valid = 1'b0;
    chk("prerst_y", y, 6'd6);
    chk("prerst_acc_q", acc_q, 4'd6);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_y", y, 6'd0);
    chk("arst_flags", flags, 4'd0);
    chk("arst_acc_q", acc_q, 4'd0);
    @(posedge clk); #1 chk("arst_held_valid", out_valid, 1'b0);
    @(negedge clk); rst = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1 set_op(4'd0, 4'd0, 4'h1, 1'b0, 1'b0);
    @(posedge clk); #1 in_valid = 1'b0;
    chk("postrst_valid", out_valid, 1'b1);
    chk("postrst_y", y, 6'b111111);
    chk("postrst_neg", flags[3], 1'b1);
    @(posedge clk); #1;
    acc_m = 0;

    // randomized traffic
    sb_on = 1'b1;
    n = 0;
    cyc = 0;
    while (n < 10000 && cyc < 60000) begin
      @(posedge clk); #1;
      a         = W'($urandom);
      b         = W'($urandom);
      sel       = 4'($urandom);
      acc_sel   = 1'($urandom);
      acc_wr    = 1'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      #1 push_if_xfer(n);
      cyc++;
    end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("random_issued", n, 10000);
    chk("sb_drained", sbq.size(), 0);
    chk("final_idle", out_valid, 1'b0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
